// File: rtl/pulse_divider_if.sv
// ---------------------------------------------------------------------------
// pulse_divider_if
// Control and status bundle for the programmable pulse divider.
//   enable     1 = count, 0 = freeze counter and output
//   mode       0 = TOGGLE (square wave, period 2*D), 1 = STROBE (1-cycle pulse)
//   load       capture div_in on this edge
//   div_in     new divisor value (WIDTH bits, 0 is rejected)
//   signal     divided output
//   tick       one-cycle terminal-count strobe
//   load_err   one-cycle flag: load attempted with div_in == 0
//   div_q      currently active divisor
//   tick_count free-running count of issued ticks (only with
//              PULSE_DIVIDER_TICKCNT_EN defined)
// master: the block driving the controls; slave: the divider itself.
// ---------------------------------------------------------------------------
interface pulse_divider_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] div_in;
   logic             signal;
   logic             tick;
   logic             load_err;
   logic [WIDTH-1:0] div_q;
`ifdef PULSE_DIVIDER_TICKCNT_EN
   logic [15:0]      tick_count;
`endif

   modport master (
      output enable, mode, load, div_in,
`ifdef PULSE_DIVIDER_TICKCNT_EN
      input  tick_count,
`endif
      input  signal, tick, load_err, div_q
   );

   modport slave (
      input  enable, mode, load, div_in,
`ifdef PULSE_DIVIDER_TICKCNT_EN
      output tick_count,
`endif
      output signal, tick, load_err, div_q
   );
endinterface

// File: rtl/pulse_divider.sv
// ---------------------------------------------------------------------------
// pulse_divider
// Run-time programmable clock divider / pulse generator. Divides clock by the
// loaded divisor D; TOGGLE mode gives a square wave of period 2*D, STROBE mode
// a one-cycle pulse every D enabled cycles.
// Ports:
//   clock  system clock, all state updates on posedge
//   reset  synchronous, active-high reset
//   bus    pulse_divider_if.slave (enable, mode, load, div_in in;
//          signal, tick, load_err, div_q [, tick_count] out)
// Parameters: WIDTH (divisor/counter width), DEFAULT_DIV (divisor at reset).
// Optional feature macro: PULSE_DIVIDER_TICKCNT_EN adds the 16-bit wrapping
// tick_count output.
// All outputs are registered.
// ---------------------------------------------------------------------------
module pulse_divider #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic           clock,
   input  logic           reset,
   pulse_divider_if.slave bus
);
   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] cnt, cnt_next;
   logic [WIDTH-1:0] div_reg, div_next;
   logic             mode_q, mode_next;
   logic             signal_q, signal_next;
   logic             tick_q, tick_next;
   logic             err_q, err_next;
   logic             mode_chg;
   logic             load_ok;
   logic             at_term;

   always_comb begin
      cnt_next    = cnt;
      div_next    = div_reg;
      mode_next   = mode_q;
      signal_next = signal_q;
      tick_next   = 1'b0;
      err_next    = 1'b0;
      // Mode is only sampled while enabled, so a change during a gap waits.
      mode_chg    = bus.enable && (bus.mode != mode_q);
      load_ok     = bus.load && (bus.div_in != '0);
      at_term     = (cnt == div_reg - WIDTH'(1));

      if (bus.load || mode_chg) begin
         // Load and mode change consume the edge: no count, no tick.
         if (load_ok) begin
            div_next = bus.div_in;
            cnt_next = '0;
         end
         if (bus.load && !load_ok) begin
            err_next = 1'b1;
         end
         if (mode_chg) begin
            mode_next   = bus.mode;
            cnt_next    = '0;
            signal_next = 1'b0;
         end
      end else if (!bus.enable) begin
         if (mode_q) begin
            signal_next = 1'b0;
         end
      end else if (at_term) begin
         cnt_next    = '0;
         tick_next   = 1'b1;
         signal_next = mode_q ? 1'b1 : ~signal_q;
      end else begin
         cnt_next = cnt + WIDTH'(1);
         if (mode_q) begin
            signal_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         div_reg  <= DEF_DIV;
         mode_q   <= 1'b0;
         signal_q <= 1'b0;
         tick_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt      <= cnt_next;
         div_reg  <= div_next;
         mode_q   <= mode_next;
         signal_q <= signal_next;
         tick_q   <= tick_next;
         err_q    <= err_next;
      end
   end

`ifdef PULSE_DIVIDER_TICKCNT_EN
   logic [15:0] tick_total;

   // Counts alongside the tick register so the value seen with a tick
   // already includes that tick; wraps naturally at 16 bits.
   always_ff @(posedge clock) begin
      if (reset) begin
         tick_total <= '0;
      end else if (tick_next) begin
         tick_total <= tick_total + 16'd1;
      end
   end

   assign bus.tick_count = tick_total;
`endif

   assign bus.signal   = signal_q;
   assign bus.tick     = tick_q;
   assign bus.load_err = err_q;
   assign bus.div_q    = div_reg;
endmodule

// File: tb/tb_pulse_divider.sv
// ---------------------------------------------------------------------------
// tb_pulse_divider
// Self-checking bench for pulse_divider: a table of hand-computed vectors,
// directed multi-cycle sequences and randomized traffic, all cross-checked
// every cycle against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_pulse_divider;
   localparam int WIDTH = 8;
   localparam int DEF   = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   pulse_divider_if #(.WIDTH(WIDTH)) bus ();
   pulse_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: ticks fall where the number of enabled counting edges
   // since the last restart is a multiple of the divisor.
   int m_div, m_since, m_tc;
   bit m_mode, m_sig, m_tick, m_err;

   function automatic void model_step(input bit rst, input bit en, input bit md,
                                      input bit ld, input int din);
      bit mchg;
      if (rst) begin
         m_div = DEF; m_since = 0; m_mode = 0; m_sig = 0;
         m_tick = 0; m_err = 0; m_tc = 0;
         return;
      end
      m_tick = 0;
      m_err  = 0;
      mchg   = en && (md != m_mode);
      if (ld || mchg) begin
         if (ld && din != 0) begin m_div = din; m_since = 0; end
         if (ld && din == 0) m_err = 1;
         if (mchg) begin m_mode = md; m_since = 0; m_sig = 0; end
      end else if (en) begin
         m_since++;
         if (m_since % m_div == 0) begin
            m_tick = 1;
            m_sig  = m_mode ? 1'b1 : !m_sig;
         end else if (m_mode) begin
            m_sig = 0;
         end
      end else if (m_mode) begin
         m_sig = 0;
      end
      if (m_tick) m_tc = (m_tc + 1) % 65536;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   // One clock: drive on the falling edge, advance the model on the rising
   // edge, compare 1 time unit later.
   task automatic step(input bit rst, input bit en, input bit md, input bit ld, input int din);
      @(negedge clock);
      reset      = rst;
      bus.enable = en;
      bus.mode   = md;
      bus.load   = ld;
      bus.div_in = WIDTH'(din);
      @(posedge clock);
      cyc++;
      model_step(rst, en, md, ld, din);
      #1;
      check("model_signal", {31'd0, bus.signal}, {31'd0, m_sig});
      check("model_tick", {31'd0, bus.tick}, {31'd0, m_tick});
      check("model_load_err", {31'd0, bus.load_err}, {31'd0, m_err});
      check("model_div_q", {24'd0, bus.div_q}, m_div);
`ifdef PULSE_DIVIDER_TICKCNT_EN
      check("model_tick_count", {16'd0, bus.tick_count}, m_tc);
`endif
   endtask

   typedef struct {
      bit en, md, ld;
      int din;
      bit exp_sig, exp_tick, exp_err;
      int exp_div;
   } vec_t;

   vec_t vecs[20];

   initial begin
      int n_t, n_rise, first, bad, prev, t_a, t_b, obs_ticks;
      bit cur_md;

      bus.enable = 0; bus.mode = 0; bus.load = 0; bus.div_in = '0;

      //            en md ld din  sig tick err div
      vecs[0]  = '{1, 0, 0, 0,   0, 0, 0, 3};
      vecs[1]  = '{1, 0, 0, 0,   0, 0, 0, 3};
      vecs[2]  = '{1, 0, 0, 0,   1, 1, 0, 3};
      vecs[3]  = '{1, 0, 0, 0,   1, 0, 0, 3};
      vecs[4]  = '{1, 0, 0, 0,   1, 0, 0, 3};
      vecs[5]  = '{1, 0, 0, 0,   0, 1, 0, 3};
      vecs[6]  = '{1, 0, 1, 0,   0, 0, 1, 3};
      vecs[7]  = '{1, 0, 0, 0,   0, 0, 0, 3};
      vecs[8]  = '{1, 0, 1, 2,   0, 0, 0, 2};
      vecs[9]  = '{1, 0, 0, 0,   0, 0, 0, 2};
      vecs[10] = '{1, 0, 0, 0,   1, 1, 0, 2};
      vecs[11] = '{1, 1, 0, 0,   0, 0, 0, 2};
      vecs[12] = '{1, 1, 0, 0,   0, 0, 0, 2};
      vecs[13] = '{1, 1, 0, 0,   1, 1, 0, 2};
      vecs[14] = '{0, 1, 0, 0,   0, 0, 0, 2};
      vecs[15] = '{1, 1, 0, 0,   0, 0, 0, 2};
      vecs[16] = '{1, 1, 0, 0,   1, 1, 0, 2};
      vecs[17] = '{1, 0, 1, 1,   0, 0, 0, 1};
      vecs[18] = '{1, 0, 0, 0,   1, 1, 0, 1};
      vecs[19] = '{1, 0, 0, 0,   0, 1, 0, 1};

      // Reset state
      step(1, 0, 0, 0, 0);
      check("rst_signal", {31'd0, bus.signal}, 0);
      check("rst_tick", {31'd0, bus.tick}, 0);
      check("rst_load_err", {31'd0, bus.load_err}, 0);
      check("rst_div_q", {24'd0, bus.div_q}, DEF);

      // Table vectors
      for (int i = 0; i < 20; i++) begin
         step(0, vecs[i].en, vecs[i].md, vecs[i].ld, vecs[i].din);
         check($sformatf("vec%0d_signal", i), {31'd0, bus.signal}, {31'd0, vecs[i].exp_sig});
         check($sformatf("vec%0d_tick", i), {31'd0, bus.tick}, {31'd0, vecs[i].exp_tick});
         check($sformatf("vec%0d_load_err", i), {31'd0, bus.load_err}, {31'd0, vecs[i].exp_err});
         check($sformatf("vec%0d_div_q", i), {24'd0, bus.div_q}, vecs[i].exp_div);
      end

      // Default D=3 TOGGLE for 48 cycles
      step(1, 0, 0, 0, 0);
      n_t = 0; n_rise = 0; prev = 0;
      for (int i = 0; i < 48; i++) begin
         step(0, 1, 0, 0, 0);
         if (bus.tick) n_t++;
         if (bus.signal && prev == 0) n_rise++;
         prev = bus.signal;
      end
      check("t1_ticks", n_t, 16);
      check("t1_periods", n_rise, 8);

      // STROBE with D=5 loaded together with the mode switch
      step(0, 1, 1, 1, 5);
      n_t = 0; first = 0; bad = 0;
      for (int i = 1; i <= 25; i++) begin
         step(0, 1, 1, 0, 0);
         if (bus.tick) begin n_t++; if (first == 0) first = i; end
         if (bus.signal != bus.tick) bad++;
      end
      check("t2_first_tick", first, 5);
      check("t2_ticks", n_t, 5);
      check("t2_signal_eq_tick", bad, 0);

      // Rejected load of 0 while D=4
      step(0, 1, 0, 1, 4);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      check("t3_err_set", {31'd0, bus.load_err}, 1);
      check("t3_div_kept", {24'd0, bus.div_q}, 4);
      step(0, 1, 0, 0, 0);
      check("t3_err_one_cycle", {31'd0, bus.load_err}, 0);
      t_a = -1; t_b = -1;
      for (int i = 0; i < 12; i++) begin
         step(0, 1, 0, 0, 0);
         if (bus.tick) begin
            if (t_a < 0) t_a = i; else if (t_b < 0) t_b = i;
         end
      end
      check("t3_tick_spacing", t_b - t_a, 4);

      // Enable gap at cnt=2 with D=4
      step(0, 1, 0, 1, 4);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      n_t = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 0);
         if (bus.tick) n_t++;
      end
      check("t4_gap_no_tick", n_t, 0);
      step(0, 1, 0, 0, 0);
      check("t4_reenable_1", {31'd0, bus.tick}, 0);
      step(0, 1, 0, 0, 0);
      check("t4_reenable_2", {31'd0, bus.tick}, 1);

      // Load on terminal-count edge, then reset mid-count
      step(1, 0, 0, 0, 0);
      obs_ticks = 0;
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 2);
      check("t5_no_tick_on_load", {31'd0, bus.tick}, 0);
      check("t5_div_loaded", {24'd0, bus.div_q}, 2);
      step(0, 1, 0, 0, 0);
      if (bus.tick) obs_ticks++;
      step(1, 1, 0, 0, 0);
      obs_ticks = 0;
      check("t5_rst_div", {24'd0, bus.div_q}, 3);
      check("t5_rst_signal", {31'd0, bus.signal}, 0);
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 0, 0, 0);
         if (bus.tick) obs_ticks++;
         check($sformatf("t5_cnt_restart_%0d", i), {31'd0, bus.tick}, (i == 3) ? 1 : 0);
      end

      // D=1 TOGGLE, then switch to STROBE
      step(0, 1, 0, 1, 1);
      prev = bus.signal;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 0, 0);
         if (bus.tick) obs_ticks++;
         if (bus.signal == prev) bad++;
         prev = bus.signal;
      end
      check("t6_alternate", bad, 0);
      step(0, 1, 1, 0, 0);
      check("t6_switch_signal", {31'd0, bus.signal}, 0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 0, 0);
         if (bus.tick) obs_ticks++;
         if (!bus.signal || !bus.tick) bad++;
      end
      check("t6_strobe_const", bad, 0);
`ifdef PULSE_DIVIDER_TICKCNT_EN
      check("t6_tick_count", {16'd0, bus.tick_count}, obs_ticks);
`endif

      // Largest divisor
      step(0, 1, 0, 1, 255);
      t_a = -1; t_b = -1;
      for (int i = 1; i <= 520; i++) begin
         step(0, 1, 0, 0, 0);
         if (bus.tick) begin
            if (t_a < 0) t_a = i; else if (t_b < 0) t_b = i;
         end
      end
      check("max_first_tick", t_a, 255);
      check("max_second_tick", t_b, 510);

      // Randomized traffic against the model
      cur_md = m_mode;
      for (int i = 0; i < 3000; i++) begin
         bit r_rst, r_en, r_ld;
         int r_din;
         r_rst = ($urandom % 250) == 0;
         r_en  = ($urandom % 8) != 0;
         if (($urandom % 60) == 0) cur_md = ~cur_md;
         r_ld  = ($urandom % 25) == 0;
         r_din = (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 12));
         step(r_rst, r_en, cur_md, r_ld, r_din);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
